// File: rtl/sram_like_resp.sv
// Memory-side responder for an SRAM-like addr_ok/data_ok bus: word array, in-order fixed-latency responses.
// Optional misalignment checking with a resp_err output when SRAM_RESP_MISALIGN_CHK_EN is defined.
module sram_like_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LAT        = 2,
    parameter int unsigned MAX_OUT    = 2
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
`ifdef SRAM_RESP_MISALIGN_CHK_EN
    ,
    output logic        resp_err_o
`endif
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CntW  = $clog2(MAX_OUT + 1);
    localparam logic [3:0]      AgeInit = 4'(LAT - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUT);

    logic [31:0] mem_q [Depth];

    logic        is_rd_q [MAX_OUT];
    logic        is_rd_d [MAX_OUT];
    logic [31:0] snap_q  [MAX_OUT];
    logic [31:0] snap_d  [MAX_OUT];
    logic        err_q   [MAX_OUT];
    logic        err_d   [MAX_OUT];
    logic [3:0]  age_q   [MAX_OUT];
    logic [3:0]  age_d   [MAX_OUT];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            data_ok_q, data_ok_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept, pop, misalign;
    logic                  unused_bits;

    assign idx         = addr_i[DEPTH_LOG2+1:2];
    assign unused_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0], size_i, resp_err_q};

`ifdef SRAM_RESP_MISALIGN_CHK_EN
    assign misalign = ((size_i == 2'd1) & addr_i[0]) | ((size_i >= 2'd2) & (addr_i[1:0] != 2'b00));
    assign resp_err_o = resp_err_q;
`else
    assign misalign = 1'b0;
`endif

    // No bypass: a pop in the same cycle does not reopen a full FIFO.
    assign addr_ok_o = (count_q < CntMax);
    assign accept    = req_i & addr_ok_o;
    assign pop       = (count_q != '0) && (age_q[rd_ptr_q] == 4'd0);
    assign data_ok_o = data_ok_q;
    assign rdata_o   = rdata_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_ok_d  = 1'b0;
        rdata_d    = 32'd0;
        resp_err_d = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            is_rd_d[i] = is_rd_q[i];
            snap_d[i]  = snap_q[i];
            err_d[i]   = err_q[i];
            age_d[i]   = (age_q[i] != 4'd0) ? age_q[i] - 4'd1 : 4'd0;
        end
        if (pop) begin
            data_ok_d  = 1'b1;
            rdata_d    = is_rd_q[rd_ptr_q] ? snap_q[rd_ptr_q] : 32'd0;
            resp_err_d = err_q[rd_ptr_q];
            rd_ptr_d   = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (accept) begin
            is_rd_d[wr_ptr_q] = ~wr_i;
            snap_d[wr_ptr_q]  = (~wr_i & ~misalign) ? mem_q[idx] : 32'd0;
            err_d[wr_ptr_q]   = misalign;
            age_d[wr_ptr_q]   = AgeInit;
            wr_ptr_d          = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_ok_q  <= 1'b0;
            rdata_q    <= 32'd0;
            resp_err_q <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                is_rd_q[i] <= 1'b0;
                snap_q[i]  <= 32'd0;
                err_q[i]   <= 1'b0;
                age_q[i]   <= 4'd0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_ok_q  <= data_ok_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
            for (int i = 0; i < MAX_OUT; i++) begin
                is_rd_q[i] <= is_rd_d[i];
                snap_q[i]  <= snap_d[i];
                err_q[i]   <= err_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    // Storage is deliberately not reset; accepted writes survive a reset.
    always_ff @(posedge clk_i) begin
        if (accept && wr_i && !misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed self-checking bench for sram_like_resp at default parameters (LAT=2, MAX_OUT=2).
module tb_sram_like_resp;

    localparam int unsigned LAT = 2;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        req_i;
    logic        wr_i;
    logic [1:0]  size_i;
    logic [3:0]  wstrb_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        addr_ok_o;
    logic        data_ok_o;
    logic [31:0] rdata_o;
    logic        obs_err;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    sram_like_resp dut (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .req_i     (req_i),
        .wr_i      (wr_i),
        .size_i    (size_i),
        .wstrb_i   (wstrb_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .addr_ok_o (addr_ok_o),
        .data_ok_o (data_ok_o),
        .rdata_o   (rdata_o)
`ifdef SRAM_RESP_MISALIGN_CHK_EN
        ,
        .resp_err_o(obs_err)
`endif
    );

`ifndef SRAM_RESP_MISALIGN_CHK_EN
    assign obs_err = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request and check the full response timing: quiet until LAT edges, then one pulse.
    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err);
        req_i = 1'b1; wr_i = w; size_i = sz; wstrb_i = st; addr_i = a; wdata_i = d;
        chk($sformatf("%s.addr_ok", tag), {32'd0, addr_ok_o}, 33'd1);
        step();
        req_i = 1'b0; wr_i = 1'b0; wstrb_i = 4'h0;
        for (int i = 1; i < LAT; i++) begin
            step();
            chk($sformatf("%s.early", tag), {32'd0, data_ok_o}, 33'd0);
        end
        step();
        chk($sformatf("%s.data_ok", tag), {32'd0, data_ok_o}, 33'd1);
        chk($sformatf("%s.resp", tag), {obs_err, rdata_o}, {exp_err, exp_rd});
        step();
        chk($sformatf("%s.pulse_end", tag), {data_ok_o, rdata_o}, 33'd0);
    endtask

    initial begin
        resetn_i = 1'b0; req_i = 1'b0; wr_i = 1'b0; size_i = 2'd2; wstrb_i = 4'h0;
        addr_i = 32'd0; wdata_i = 32'd0;
        #2;
        chk("reset.addr_ok", {32'd0, addr_ok_o}, 33'd1);
        chk("reset.outs", {obs_err, data_ok_o, rdata_o[30:0]}, 33'd0);
        chk("reset.rdata", {1'b0, rdata_o}, 33'd0);
        step();
        step();
        resetn_i = 1'b1;

        // Word write then read back.
        txn("wr_word", 1'b1, 2'd2, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("rd_word", 1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte-lane store into the middle of a word.
        txn("wr_base", 1'b1, 2'd2, 4'hF, 32'h100, 32'h11223344, 32'h0, 1'b0);
        txn("wr_byte", 1'b1, 2'd0, 4'b0010, 32'h101, 32'h0000AB00, 32'h0, 1'b0);
        txn("rd_byte", 1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 32'h1122AB44, 1'b0);

        // Back-to-back reads against a 2-deep response FIFO.
        txn("fill0", 1'b1, 2'd2, 4'hF, 32'h200, 32'hA1A1A1A1, 32'h0, 1'b0);
        txn("fill1", 1'b1, 2'd2, 4'hF, 32'h204, 32'hB2B2B2B2, 32'h0, 1'b0);
        txn("fill2", 1'b1, 2'd2, 4'hF, 32'h208, 32'hC3C3C3C3, 32'h0, 1'b0);
        req_i = 1'b1; wr_i = 1'b0; size_i = 2'd2; addr_i = 32'h200;
        chk("full.ok0", {32'd0, addr_ok_o}, 33'd1);
        step();
        addr_i = 32'h204;
        chk("full.ok1", {32'd0, addr_ok_o}, 33'd1);
        chk("full.quiet0", {32'd0, data_ok_o}, 33'd0);
        step();
        addr_i = 32'h208;
        chk("full.ok2", {32'd0, addr_ok_o}, 33'd0);
        chk("full.quiet1", {32'd0, data_ok_o}, 33'd0);
        step();
        chk("full.resp0", {data_ok_o, rdata_o}, {1'b1, 32'hA1A1A1A1});
        chk("full.reopen", {32'd0, addr_ok_o}, 33'd1);
        step();
        req_i = 1'b0;
        chk("full.resp1", {data_ok_o, rdata_o}, {1'b1, 32'hB2B2B2B2});
        chk("full.ok_after", {32'd0, addr_ok_o}, 33'd1);
        step();
        chk("full.gap", {data_ok_o, rdata_o}, 33'd0);
        step();
        chk("full.resp2", {data_ok_o, rdata_o}, {1'b1, 32'hC3C3C3C3});
        step();
        chk("full.drained", {data_ok_o, rdata_o}, 33'd0);

        // Reset with two reads in flight.
        txn("rst_wr", 1'b1, 2'd2, 4'hF, 32'h300, 32'h00000077, 32'h0, 1'b0);
        req_i = 1'b1; wr_i = 1'b0; addr_i = 32'h300;
        step();
        step();
        req_i = 1'b0;
        resetn_i = 1'b0;
        #1;
        chk("rst.during_ok", {32'd0, addr_ok_o}, 33'd1);
        chk("rst.during_dok", {32'd0, data_ok_o}, 33'd0);
        step();
        resetn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst.after%0d", i), {addr_ok_o, data_ok_o, rdata_o[30:0]}, {1'b1, 32'd0});
        end
        txn("rst_rd", 1'b0, 2'd2, 4'h0, 32'h300, 32'h0, 32'h00000077, 1'b0);

        // Address aliasing above the array size.
        txn("alias_wr", 1'b1, 2'd2, 4'hF, 32'h0, 32'h00000005, 32'h0, 1'b0);
        txn("alias_rd", 1'b0, 2'd2, 4'h0, 32'h1000, 32'h0, 32'h00000005, 1'b0);

`ifdef SRAM_RESP_MISALIGN_CHK_EN
        txn("mis_wr", 1'b1, 2'd2, 4'hF, 32'h102, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("mis_chk", 1'b0, 2'd2, 4'h0, 32'h100, 32'h0, 32'h1122AB44, 1'b0);
        txn("mis_rd", 1'b0, 2'd1, 4'h0, 32'h101, 32'h0, 32'h0, 1'b1);
`else
        // Low address bits are ignored for indexing.
        txn("low_wr", 1'b1, 2'd2, 4'hF, 32'h10B, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("low_rd", 1'b0, 2'd2, 4'h0, 32'h108, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
